// File: rtl/mul_8_bit_seq_pkg.sv
// Shared arithmetic definitions for the sequential 8x8 multiplier.
// Holds the FSM state encoding, the operand/product width constants and
// the per-step partial-product shift lookup.
package mul_8_bit_seq_pkg;

    localparam int OP_W  = 8;
    localparam int NIB_W = 4;
    localparam int P_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit weight of each partial product: lo*lo, hi*lo, lo*hi, hi*hi.
    function automatic logic [3:0] pp_shift(input logic [1:0] step);
        case (step)
            2'd0:    pp_shift = 4'd0;
            2'd1:    pp_shift = 4'd4;
            2'd2:    pp_shift = 4'd4;
            default: pp_shift = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mul_4_bit.sv
// Combinational 4x4 unsigned multiplier.
// Ports:
//   i_a  [3:0]  multiplicand nibble
//   i_b  [3:0]  multiplier nibble
//   o_p  [7:0]  unsigned product
module mul_4_bit
    import mul_8_bit_seq_pkg::*;
(
    input  logic [NIB_W-1:0]   i_a,
    input  logic [NIB_W-1:0]   i_b,
    output logic [2*NIB_W-1:0] o_p
);

    assign o_p = (2*NIB_W)'(i_a) * (2*NIB_W)'(i_b);

endmodule

// File: rtl/mul_8_bit_seq.sv
// Sequential 8x8 unsigned multiplier that reuses one 4x4 multiplier over
// four cycles, accumulating shifted partial products into a 16-bit sum.
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands A/B present
//   in_ready   block can accept operands (IDLE only)
//   A, B       8-bit unsigned operands
//   abort      cancel the operation in flight
//   out_valid  P holds a completed product (DONE only)
//   out_ready  consumer accepts P
//   P          16-bit product, forced to 0 while out_valid is low
//   busy       high in any state other than IDLE
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one partial product accumulated per edge, step 0..3
// DONE  | product presented, waiting for out_ready
module mul_8_bit_seq
    import mul_8_bit_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] A,
    input  logic [OP_W-1:0] B,
    input  logic            abort,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [P_W-1:0]  P,
    output logic            busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_step;
    logic [1:0]      w_step_nxt;
    logic [P_W-1:0]  r_acc;
    logic [P_W-1:0]  w_acc_nxt;
    logic [OP_W-1:0] r_a;
    logic [OP_W-1:0] w_a_nxt;
    logic [OP_W-1:0] r_b;
    logic [OP_W-1:0] w_b_nxt;

    logic [NIB_W-1:0]   w_nib_a;
    logic [NIB_W-1:0]   w_nib_b;
    logic [2*NIB_W-1:0] w_pp;
    logic [P_W-1:0]     w_pp_shifted;

    // Step bit 0 picks the A nibble, step bit 1 picks the B nibble.
    assign w_nib_a = r_step[0] ? r_a[7:4] : r_a[3:0];
    assign w_nib_b = r_step[1] ? r_b[7:4] : r_b[3:0];

    mul_4_bit u_mul_4_bit (
        .i_a (w_nib_a),
        .i_b (w_nib_b),
        .o_p (w_pp)
    );

    assign w_pp_shifted = P_W'(w_pp) << pp_shift(r_step);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= 2'd0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_acc   <= w_acc_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_acc_nxt   = r_acc;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        case (r_state)
            IDLE: begin
                // abort in IDLE suppresses acceptance on that edge
                if (in_valid && !abort) begin
                    w_a_nxt     = A;
                    w_b_nxt     = B;
                    w_acc_nxt   = '0;
                    w_step_nxt  = 2'd0;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (abort) begin
                    w_acc_nxt   = '0;
                    w_step_nxt  = 2'd0;
                    w_state_nxt = IDLE;
                end else begin
                    // Max final sum is 0xFE01, so the 16-bit add never wraps.
                    w_acc_nxt  = r_acc + w_pp_shifted;
                    w_step_nxt = r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    w_step_nxt  = 2'd0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_step_nxt  = 2'd0;
                w_acc_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign P         = out_valid ? r_acc : '0;

endmodule

// File: tb/tb_mul_8_bit_seq.sv
module tb_mul_8_bit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] P;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_8_bit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_p;
        int          hold;
        bit          scramble;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Full transaction from IDLE: accept, wait for result, hold, handshake.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input int hold, input bit scramble);
        int lat;
        chk("pre_in_ready", 16'(in_ready), 16'd1);
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        step_clk();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            chk("calc_busy", 16'(busy), 16'd1);
            chk("calc_in_ready", 16'(in_ready), 16'd0);
            chk("calc_p_zero", P, 16'd0);
            if (scramble) begin
                A        = 8'($urandom);
                B        = 8'($urandom);
                in_valid = 1'b1;
            end
            step_clk();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 16'(lat), 16'd4);
        chk("product", P, exp_p);
        for (int i = 0; i < hold; i++) begin
            step_clk();
            chk("hold_valid", 16'(out_valid), 16'd1);
            chk("hold_p", P, exp_p);
            chk("hold_in_ready", 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1;
        step_clk();
        out_ready = 1'b0;
        chk("post_valid", 16'(out_valid), 16'd0);
        chk("post_in_ready", 16'(in_ready), 16'd1);
        chk("post_busy", 16'(busy), 16'd0);
        chk("post_p", P, 16'd0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_in_ready"}, 16'(in_ready), 16'd1);
        chk({name, "_out_valid"}, 16'(out_valid), 16'd0);
        chk({name, "_busy"}, 16'(busy), 16'd0);
        chk({name, "_p"}, P, 16'd0);
    endtask

    initial begin
        vecs[0] = '{8'h12, 8'h34, 16'h03A8, 0, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 0, 1'b0};
        vecs[2] = '{8'h00, 8'hAB, 16'h0000, 0, 1'b0};
        vecs[3] = '{8'h01, 8'h80, 16'h0080, 0, 1'b0};
        vecs[4] = '{8'h9C, 8'h47, 16'h2B44, 3, 1'b0};
        vecs[5] = '{8'h37, 8'hC2, 16'h29AE, 0, 1'b1};
        vecs[6] = '{8'h0F, 8'h0F, 16'h00E1, 1, 1'b0};
        vecs[7] = '{8'hF0, 8'h0F, 16'h0E10, 0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = 8'h00;
        B         = 8'h00;
        abort     = 1'b0;
        out_ready = 1'b0;
        step_clk();
        step_clk();
        chk_idle("reset_held");
        rst_n = 1'b1;
        step_clk();
        chk_idle("reset");

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].hold, vecs[i].scramble);
        end

        // Back-to-back throughput: accepting edges 6 cycles apart.
        begin
            int t0;
            int t1;
            t0 = int'($time);
            do_op(8'h03, 8'h05, 16'h000F, 0, 1'b0);
            t1 = int'($time);
            chk("throughput_cycles", 16'((t1 - t0) / 10), 16'd6);
        end

        // Abort in IDLE blocks acceptance.
        A        = 8'h11;
        B        = 8'h22;
        in_valid = 1'b1;
        abort    = 1'b1;
        step_clk();
        in_valid = 1'b0;
        abort    = 1'b0;
        chk_idle("abort_idle");

        // Abort at step2.
        A        = 8'hAA;
        B        = 8'h55;
        in_valid = 1'b1;
        step_clk();
        in_valid = 1'b0;
        step_clk();
        step_clk();
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        chk_idle("abort_calc");
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                step_clk();
                if (out_valid) seen++;
            end
            chk("abort_no_valid", 16'(seen), 16'd0);
        end
        do_op(8'h0F, 8'h10, 16'h00F0, 0, 1'b0);

        // Abort while DONE discards the result.
        A        = 8'h44;
        B        = 8'h44;
        in_valid = 1'b1;
        step_clk();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step_clk();
        chk("done_before_abort", 16'(out_valid), 16'd1);
        chk("done_p", P, 16'h1210);
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        chk_idle("abort_done");

        // Reset mid-CALC.
        A        = 8'h77;
        B        = 8'h66;
        in_valid = 1'b1;
        step_clk();
        in_valid = 1'b0;
        step_clk();
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        chk_idle("reset_calc");
        begin
            int seen = 0;
            for (int i = 0; i < 5; i++) begin
                step_clk();
                if (out_valid) seen++;
            end
            chk("reset_no_valid", 16'(seen), 16'd0);
        end
        do_op(8'h20, 8'h08, 16'h0100, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_8_bit_seq.md
MUL_8_BIT_SEQ -- requirements
Module: mul_8_bit_seq

Interface
REQ-001 Parameter: none; operand width fixed at 8 bits, product width 16 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operands A/B present.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 A  input  8  unsigned multiplicand.
REQ-007 B  input  8  unsigned multiplier.
REQ-008 abort  input  1  synchronous cancel of the operation in flight.
REQ-009 out_valid  output  1  P holds a completed product.
REQ-010 out_ready  input  1  consumer accepts P.
REQ-011 P  output  16  unsigned product A*B.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The product SHALL be computed by time-sharing exactly one 4x4 unsigned multiplier across four partial products.
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur at an edge where in_valid=1 and in_ready=1: latch A, B; clear accumulator; step:=0; go to CALC.
REQ-017 In CALC, each edge SHALL add one shifted partial product to the 16-bit accumulator, with step advancing 0->1->2->3.
  - step0: A[3:0]*B[3:0], shift 0
  - step1: A[7:4]*B[3:0], shift 4
  - step2: A[3:0]*B[7:4], shift 4
  - step3: A[7:4]*B[7:4], shift 8
REQ-018 At the step3 edge the state SHALL go to DONE; out_valid SHALL be visible 4 edges after the accepting edge.
REQ-019 Accumulator additions SHALL be 16-bit; the final sum cannot overflow (max 0xFE01), so no carry-out is required.
REQ-020 In DONE, P and out_valid SHALL hold stable until an edge with out_ready=1, which SHALL return the state to IDLE.
REQ-021 in_ready SHALL first rise the cycle after the out_ready handshake; back-to-back throughput is one result per 6 cycles.
REQ-022 A and B changing after acceptance SHALL NOT affect the result.
REQ-023 abort=1 at an edge in CALC or DONE SHALL force IDLE, out_valid=0, and discard the result.
REQ-024 abort=1 in IDLE SHALL have no effect and SHALL block acceptance on that edge.
REQ-025 P SHALL read 0 whenever out_valid=0.

Reset
REQ-026 rst_n=0 at an edge SHALL take priority over all inputs: state=IDLE, step=0, accumulator=0, latched operands=0.
REQ-027 After reset: in_ready=1, out_valid=0, busy=0, P=0.
REQ-028 Reset mid-CALC or in DONE SHALL discard the operation with no output handshake.

Structure
REQ-029 State encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and width constants (OP_W=8, NIB_W=4, P_W=16) SHALL live in the shared arithmetic package/include file.
REQ-030 The 4x4 multiplier SHALL be a single instance of the existing mul_4_bit combinational module.
REQ-031 Nibble selection SHALL be a step-driven mux on the inputs of that instance; no second multiplier is permitted.

Verification
REQ-032 Reset, then A=0x12, B=0x34, out_ready=1 -> out_valid 4 edges after acceptance, P=0x03A8, then IDLE with in_ready=1.
REQ-033 A=0xFF, B=0xFF -> P=0xFE01; A=0x00, B=0xAB -> P=0x0000; A=0x01, B=0x80 -> P=0x0080.
REQ-034 A=0x9C, B=0x47, out_ready low for 3 cycles after out_valid -> P=0x2B44 held stable, in_ready=0 throughout, single handshake.
REQ-035 abort pulsed at step2 of A=0xAA, B=0x55 -> IDLE next edge, out_valid never asserts; next op A=0x0F, B=0x10 -> P=0x00F0.
REQ-036 rst_n low for 1 edge mid-CALC -> all outputs at reset values next cycle; subsequent op A=0x20, B=0x08 -> P=0x0100.
REQ-037 Operands changed every cycle after acceptance of A=0x37, B=0xC2 -> P=0x29AE unaffected.
